// File: rtl/dca_matrix_mreg2store.sv
// dca_matrix_mreg2store
// Drains a completed matrix out of the matrix register (mreg) row by row.
// The first num_row rows go out as a tensor-row write stream with wlast on
// the final emitted row. The remaining rows are shifted out silently, so mreg
// is empty for the next matrix.
// Optional column masking: define DCA_MATRIX_STORE_COL_MASK_EN.
module dca_matrix_mreg2store #(
    parameter int MATRIX_SIZE_PARA = 4,
    parameter int TENSOR_PARA      = 0,
    localparam int MATRIX_NUM_ROW   = (MATRIX_SIZE_PARA < 1) ? 1 : MATRIX_SIZE_PARA,
    localparam int MATRIX_NUM_COL   = (MATRIX_SIZE_PARA < 1) ? 1 : MATRIX_SIZE_PARA,
    localparam int BW_TENSOR_SCALAR = (TENSOR_PARA == 1) ? 16 :
                                      (TENSOR_PARA == 2) ? 32 : 8,
    localparam int BW_TENSOR_ROW    = BW_TENSOR_SCALAR * MATRIX_NUM_COL,
    localparam int BW_ROW_NUM       = $clog2(MATRIX_NUM_ROW + 1),
    localparam int BW_COL_NUM       = $clog2(MATRIX_NUM_COL + 1)
) (
    input  logic                     clk,
    input  logic                     rstnn,
    input  logic                     clear,
    input  logic                     enable,
    output logic                     busy,
    output logic                     storereg_wready,
    input  logic                     storereg_wrequest,
    input  logic [BW_ROW_NUM-1:0]    num_row,
`ifdef DCA_MATRIX_STORE_COL_MASK_EN
    input  logic [BW_COL_NUM-1:0]    num_col,
`endif
    output logic                     mreg_move_renable,
    input  logic [BW_TENSOR_ROW-1:0] mreg_move_rdata_list1d,
    output logic                     store_tensor_row_wvalid,
    output logic                     store_tensor_row_wlast,
    output logic [BW_TENSOR_ROW-1:0] store_tensor_row_wdata,
    input  logic                     store_tensor_row_wready
);

    localparam logic [BW_TENSOR_SCALAR-1:0] TENSOR_ZERO = '0;
    localparam logic [BW_ROW_NUM-1:0] ROW_FULL = BW_ROW_NUM'(MATRIX_NUM_ROW);
    localparam logic [BW_ROW_NUM-1:0] ROW_LAST = BW_ROW_NUM'(MATRIX_NUM_ROW - 1);
    localparam logic [BW_ROW_NUM-1:0] ROW_ONE  = BW_ROW_NUM'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    logic [BW_ROW_NUM-1:0] row_idx;
    logic [BW_ROW_NUM-1:0] num_row_q;
    logic [BW_ROW_NUM-1:0] num_row_clamped;
    logic                  hs;
    logic                  is_last;

`ifdef DCA_MATRIX_STORE_COL_MASK_EN
    localparam logic [BW_COL_NUM-1:0] COL_FULL = BW_COL_NUM'(MATRIX_NUM_COL);
    logic [BW_COL_NUM-1:0] num_col_q;
    logic [BW_COL_NUM-1:0] num_col_clamped;

    // Zero or out-of-range column counts mean "all columns"
    always_comb begin
        num_col_clamped = num_col;
        if ((num_col == '0) || (num_col > COL_FULL))
            num_col_clamped = COL_FULL;
    end
`endif

    // Zero or out-of-range row counts mean "all rows"
    always_comb begin
        num_row_clamped = num_row;
        if ((num_row == '0) || (num_row > ROW_FULL))
            num_row_clamped = ROW_FULL;
    end

    assign is_last                 = (row_idx == (num_row_q - ROW_ONE));
    assign store_tensor_row_wvalid = enable & (state == SEND);
    assign store_tensor_row_wlast  = (state == SEND) & is_last;
    assign hs                      = store_tensor_row_wvalid & store_tensor_row_wready;
    // mreg shifts on every accepted beat and on every enabled drain cycle
    assign mreg_move_renable       = hs | (enable & (state == DRAIN));
    assign storereg_wready         = (state == IDLE);
    assign busy                    = (state != IDLE);

    // Row data passes straight through from the mreg head, optionally column-masked
    always_comb begin
        store_tensor_row_wdata = mreg_move_rdata_list1d;
`ifdef DCA_MATRIX_STORE_COL_MASK_EN
        for (int unsigned i = 0; i < MATRIX_NUM_COL; i++) begin
            if (i >= 32'(num_col_q))
                store_tensor_row_wdata[i*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR] = TENSOR_ZERO;
        end
`endif
    end

    // Control FSM: row counter, latched limits, IDLE/SEND/DRAIN sequencing
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state     <= IDLE;
            row_idx   <= '0;
            num_row_q <= ROW_FULL;
`ifdef DCA_MATRIX_STORE_COL_MASK_EN
            num_col_q <= COL_FULL;
`endif
        end else if (clear) begin
            state     <= IDLE;
            row_idx   <= '0;
            num_row_q <= ROW_FULL;
`ifdef DCA_MATRIX_STORE_COL_MASK_EN
            num_col_q <= COL_FULL;
`endif
        end else if (enable) begin
            case (state)
                IDLE: begin
                    if (storereg_wrequest) begin
                        state     <= SEND;
                        row_idx   <= '0;
                        num_row_q <= num_row_clamped;
`ifdef DCA_MATRIX_STORE_COL_MASK_EN
                        num_col_q <= num_col_clamped;
`endif
                    end
                end
                SEND: begin
                    if (hs) begin
                        if (is_last && (row_idx == ROW_LAST)) begin
                            state   <= IDLE;
                            row_idx <= '0;
                        end else begin
                            if (is_last)
                                state <= DRAIN;
                            row_idx <= row_idx + ROW_ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (row_idx == ROW_LAST) begin
                        state   <= IDLE;
                        row_idx <= '0;
                    end else begin
                        row_idx <= row_idx + ROW_ONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    row_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dca_matrix_mreg2store.sv
// tb_dca_matrix_mreg2store
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops
// and compares on each handshake. mreg is modelled as a row memory whose
// read pointer advances on every renable pulse.
// Honours DCA_MATRIX_STORE_COL_MASK_EN when defined.
module tb_dca_matrix_mreg2store;

    logic        clk = 1'b0;
    logic        rstnn;
    logic        clear;
    logic        enable;
    logic        busy;
    logic        storereg_wready;
    logic        storereg_wrequest;
    logic [2:0]  num_row;
`ifdef DCA_MATRIX_STORE_COL_MASK_EN
    logic [2:0]  num_col;
`endif
    logic        mreg_move_renable;
    logic [31:0] mreg_move_rdata_list1d;
    logic        wvalid;
    logic        wlast;
    logic [31:0] wdata;
    logic        wready;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem [0:255];
    logic [7:0]  ren_ptr = 8'd0;
    int          ren_total = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          tag = 0;
    int          exp_cols = 4;

    always #5 clk = ~clk;

    dca_matrix_mreg2store #(
        .MATRIX_SIZE_PARA(4),
        .TENSOR_PARA(0)
    ) dut (
        .clk                     (clk),
        .rstnn                   (rstnn),
        .clear                   (clear),
        .enable                  (enable),
        .busy                    (busy),
        .storereg_wready         (storereg_wready),
        .storereg_wrequest       (storereg_wrequest),
        .num_row                 (num_row),
`ifdef DCA_MATRIX_STORE_COL_MASK_EN
        .num_col                 (num_col),
`endif
        .mreg_move_renable       (mreg_move_renable),
        .mreg_move_rdata_list1d  (mreg_move_rdata_list1d),
        .store_tensor_row_wvalid (wvalid),
        .store_tensor_row_wlast  (wlast),
        .store_tensor_row_wdata  (wdata),
        .store_tensor_row_wready (wready)
    );

    // mreg model: head row selected by a pointer that advances per renable
    assign mreg_move_rdata_list1d = mem[ren_ptr];

    always @(posedge clk) begin
        if (mreg_move_renable) begin
            ren_ptr   <= ren_ptr + 8'd1;
            ren_total <= ren_total + 1;
        end
    end

    function automatic logic [31:0] row_val(input int t);
        logic [7:0] b;
        b = 8'(t * 4 + 16);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    function automatic logic [31:0] mask_cols(input logic [31:0] d, input int cols);
        logic [31:0] r;
        r = d;
        for (int i = 0; i < 4; i++)
            if (i >= cols) r[i*8 +: 8] = 8'h00;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Monitor: compare the presented beat against the scoreboard head
    always @(negedge clk) begin
        if (rstnn && wvalid) begin
            if (q.size() == 0) begin
                if (wready) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got data %h last %b expected no beat", wdata, wlast);
                end
            end else begin
                chk("beat_data", wdata, q[0].d);
                chk("beat_last", 32'(wlast), 32'(q[0].l));
                if (wready) begin
                    chk("renable_on_hs", 32'(mreg_move_renable), 32'd1);
                    void'(q.pop_front());
                end else begin
                    chk("renable_on_stall", 32'(mreg_move_renable), 32'd0);
                end
            end
        end
    end

    task automatic load_rows(output int first_tag);
        first_tag = tag;
        for (int i = 0; i < 4; i++)
            mem[ren_ptr + 8'(i)] = row_val(tag + i);
        tag += 4;
    endtask

    task automatic run_matrix(input string nm, input logic [2:0] nr, input int eff,
                              input logic [15:0] pat, input int pat_len,
                              input int dis_at, input int dis_len, input int exp_cyc);
        int base_total;
        int cyc;
        int t0;
        base_total = ren_total;
        load_rows(t0);
        for (int i = 0; i < eff; i++)
            q.push_back('{mask_cols(row_val(t0 + i), exp_cols), (i == eff - 1)});
        @(posedge clk) #1;
        chk({nm, "_wready_before"}, 32'(storereg_wready), 32'd1);
        storereg_wrequest = 1'b1;
        num_row = nr;
        @(posedge clk) #1;
        storereg_wrequest = 1'b0;
        cyc = 0;
        for (int k = 0; k < 40; k++) begin
            wready = (k < pat_len) ? pat[k] : 1'b1;
            enable = !((k >= dis_at) && (k < dis_at + dis_len));
            @(negedge clk);
            if (!enable) begin
                chk({nm, "_renable_frozen"}, 32'(mreg_move_renable), 32'd0);
                chk({nm, "_busy_frozen"}, 32'(busy), 32'd1);
            end
            @(posedge clk) #1;
            cyc = k + 1;
            if (!busy) break;
        end
        enable = 1'b1;
        wready = 1'b1;
        chk({nm, "_cycles"}, 32'(cyc), 32'(exp_cyc));
        chk({nm, "_renable_total"}, 32'(ren_total - base_total), 32'd4);
        chk({nm, "_beats_left"}, 32'(q.size()), 32'd0);
        chk({nm, "_wready_after"}, 32'(storereg_wready), 32'd1);
        q.delete();
    endtask

    initial begin
        int t0;
        rstnn = 1'b0;
        clear = 1'b0;
        enable = 1'b1;
        storereg_wrequest = 1'b0;
        num_row = 3'd4;
        wready = 1'b1;
`ifdef DCA_MATRIX_STORE_COL_MASK_EN
        num_col = 3'd4;
`endif
        for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
        #23;
        chk("rst_wvalid", 32'(wvalid), 32'd0);
        chk("rst_wlast", 32'(wlast), 32'd0);
        chk("rst_renable", 32'(mreg_move_renable), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_storereg_wready", 32'(storereg_wready), 32'd1);
        @(posedge clk) #1;
        rstnn = 1'b1;

        // full matrix, no stalls
        run_matrix("t1_full", 3'd4, 4, 16'h0, 0, 99, 0, 4);
        // back-to-back with partial emission and drain
        run_matrix("t2_two_rows", 3'd2, 2, 16'h0, 0, 99, 0, 4);
        // stalls on the second row
        run_matrix("t3_stall", 3'd3, 3, 16'b11001, 5, 99, 0, 6);
        // clamped row counts
        run_matrix("t4_zero", 3'd0, 4, 16'h0, 0, 99, 0, 4);
        run_matrix("t4_seven", 3'd7, 4, 16'h0, 0, 99, 0, 4);

        // clear after the first handshake
        load_rows(t0);
        q.push_back('{row_val(t0), 1'b0});
        @(posedge clk) #1;
        storereg_wrequest = 1'b1;
        num_row = 3'd4;
        wready = 1'b0;
        @(posedge clk) #1;
        storereg_wrequest = 1'b0;
        wready = 1'b1;
        @(posedge clk) #1;
        wready = 1'b0;
        clear = 1'b1;
        @(posedge clk) #1;
        clear = 1'b0;
        wready = 1'b1;
        chk("t5_clear_wvalid", 32'(wvalid), 32'd0);
        chk("t5_clear_busy", 32'(busy), 32'd0);
        chk("t5_clear_storereg_wready", 32'(storereg_wready), 32'd1);
        chk("t5_clear_beats_left", 32'(q.size()), 32'd0);
        q.delete();
        run_matrix("t5_restart", 3'd4, 4, 16'h0, 0, 99, 0, 4);

        // enable low during drain
`ifdef DCA_MATRIX_STORE_COL_MASK_EN
        num_col = 3'd2;
        exp_cols = 2;
`endif
        run_matrix("t6_enable_hold", 3'd1, 1, 16'h0, 0, 2, 3, 7);
`ifdef DCA_MATRIX_STORE_COL_MASK_EN
        run_matrix("t6_mask_full", 3'd4, 4, 16'h0, 0, 99, 0, 4);
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
